lsu_seq: RTL
============

// Module: lsu_seq
// PURPOSE
//  Multi-cycle load/store sequencer between the decode/execute stage and a
//  handshaked data-memory bus. It accepts one decoded memory op at a time (lw/ld/sd
//  class, with wmask and extension code) and holds the core stalled until that op
//  completes. It aligns the store data and mask to the 8-byte bus word, and extracts
//  and extends load data. A timeout counter guards against a bus that never answers.
// PARAMETERS
//  XLEN     64   data/address width
//  TIMEOUT  255  cycles allowed in ADDR+WAIT before err; 8-bit counter, range 1..255
// PORTS
//  clk            in   1     rising-edge clock
//  rst_n          in   1     synchronous reset, active-low
//  core_req       in   1     memory op present; held high until done is seen
//  core_we        in   1     1 = store, 0 = load
//  core_wmask     in   8     byte mask, LSB-aligned (sd = 8'hFF, sw = 8'h0F)
//  core_addr      in   XLEN  effective byte address
//  core_wdata     in   XLEN  store data, LSB-aligned
//  core_ext       in   4     load extend: 0 raw64, 1 sext32, 2 zext32, others = raw64
//  stall          out  1     freeze PC/pipeline
//  done           out  1     one-cycle completion pulse
//  err            out  1     one-cycle timeout pulse; coincides with done
//  ld_data        out  XLEN  extended load result; valid while done=1 and load
//  bus_valid      out  1     request valid
//  bus_ready      in   1     request accepted when bus_valid & bus_ready
//  bus_wen        out  1     write enable
//  bus_addr       out  XLEN  {core_addr[XLEN-1:3], 3'b0}
//  bus_wmask      out  8     core_wmask << addr[2:0]; bits shifted past bit 7 are dropped
//  bus_wdata      out  XLEN  core_wdata << (8*addr[2:0])
//  bus_rvalid     in   1     read data valid (loads only)
//  bus_rdata      in   XLEN  read data, whole 8-byte word
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, timeout counter=0. All registered
//   outputs are 0: bus_valid, bus_wen, bus_addr, bus_wmask, bus_wdata, done, err,
//   ld_data.
//  Reset mid-op: abort to IDLE; the bus request is dropped with no completion.
//   A late bus_rvalid is ignored in IDLE.
//  FSM:
//   IDLE: if core_req, latch we/addr/wmask/wdata/ext and the aligned bus fields,
//    set bus_valid=1, go to ADDR. Other inputs ignored.
//   ADDR: hold bus_* stable while bus_valid=1 and bus_ready=0.
//    On the handshake: bus_valid=0 next cycle.
//     store -> DONE
//     load  -> WAIT; if bus_rvalid is already high in that cycle, take the data
//              and go straight to DONE.
//   WAIT: on bus_rvalid, capture ld_data, go to DONE.
//   DONE: done=1 for exactly one cycle, then IDLE. core_req is not sampled in DONE.
//   ERR: entered from ADDR or WAIT when the counter reaches TIMEOUT.
//    Outputs: done=1, err=1, ld_data=0, bus_valid=0. Next state: IDLE.
//  Counter: cleared in IDLE; +1 per cycle in ADDR/WAIT; saturates.
//  stall is combinational:
//    (state==IDLE & core_req) | state==ADDR | state==WAIT
//   It is 0 in DONE and ERR so the core advances on the done cycle.
//  Load extract: w = bus_rdata >> (8*addr[2:0]).
//   ext=1: ld_data = {{32{w[31]}}, w[31:0]}
//   ext=2: ld_data = {32'b0, w[31:0]}
//   ext=0 or other: ld_data = w
//  Latency (ready and rvalid both at first opportunity):
//   store: req at cycle 0 -> done at cycle 2
//   load:  req at cycle 0 -> done at cycle 2 (same-cycle rvalid) or cycle 3
//  Back-to-back ops: the core presents the next op while done=1. It is accepted
//   from IDLE one cycle later.
//  At most one op is outstanding; no pipelining.
// TESTING
//  1 sd, addr=0x8000_0008, wdata=0x1122334455667788, wmask=FF, ready at once
//    -> bus_wmask=FF, bus_addr=0x8000_0008, done at cycle 2, stall high for 2 cycles
//  2 sw, addr=0x8000_0004, wmask=0F, wdata=0xDEADBEEF
//    -> bus_wmask=F0, bus_wdata=0xDEADBEEF_0000_0000
//  3 lw sext32, addr=...4, rdata=0x80000001_00000000, rvalid 3 cycles after handshake
//    -> ld_data=0xFFFFFFFF_80000001 on done; same op with ext=2 -> 0x00000000_80000001
//  4 bus_ready held 0, TIMEOUT=4
//    -> err=done=1 pulse after 4 cycles in ADDR, ld_data=0, back to IDLE, bus_valid=0
//  5 rst_n low while in WAIT, rvalid arrives after release
//    -> no done pulse, stall=0, all outputs 0
//  6 two stores back to back, bus_ready=1 throughout
//    -> two done pulses 3 cycles apart, bus_* stable from request to handshake

Source files
------------

// File: rtl/lsu_seq_if.sv
// Data-memory bus between the load/store sequencer (master) and memory (slave).
// One request in flight; loads return a whole 8-byte word on bus_rvalid.
interface lsu_seq_if #(
  parameter int XLEN = 64
);
  logic            bus_valid;
  logic            bus_ready;
  logic            bus_wen;
  logic [XLEN-1:0] bus_addr;
  logic [7:0]      bus_wmask;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_rvalid;
  logic [XLEN-1:0] bus_rdata;

  modport master (
    output bus_valid, bus_wen, bus_addr, bus_wmask, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_wen, bus_addr, bus_wmask, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_seq.sv
// Multi-cycle load/store sequencer: one op at a time, core stalled until done,
// store data/mask aligned to the 8-byte bus word, load data extracted and extended.
module lsu_seq #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_core_req,
  input  logic            i_core_we,
  input  logic [7:0]      i_core_wmask,
  input  logic [XLEN-1:0] i_core_addr,
  input  logic [XLEN-1:0] i_core_wdata,
  input  logic [3:0]      i_core_ext,
  output logic            o_stall,
  output logic            o_done,
  output logic            o_err,
  output logic [XLEN-1:0] o_ld_data,
  lsu_seq_if.master       bus
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_DONE, S_ERR} state_e;

  state_e          r_state, w_state_nxt;
  logic [7:0]      r_cnt, w_cnt_inc;
  logic            r_we;
  logic [2:0]      r_off;
  logic [3:0]      r_ext;
  logic            r_wen;
  logic [XLEN-1:0] r_addr, r_wdata, r_ld_data;
  logic [7:0]      r_wmask;

  logic            w_accept, w_hs, w_tmo, w_capture;
  logic [7:0]      w_wmask_al;
  logic [XLEN-1:0] w_wdata_al, w_rshift, w_ld_ext;

  assign w_accept  = (r_state == S_IDLE) && i_core_req;
  assign w_hs      = (r_state == S_ADDR) && bus.bus_ready;
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  // A completion seen in the same cycle the budget runs out still wins.
  assign w_tmo     = (w_cnt_inc == 8'(TIMEOUT));
  assign w_capture = bus.bus_rvalid && !r_we && (w_hs || (r_state == S_WAIT));

  // Mask bits shifted past byte 7 fall off the 8-bit result.
  assign w_wmask_al = i_core_wmask << i_core_addr[2:0];
  assign w_wdata_al = i_core_wdata << {i_core_addr[2:0], 3'b000};
  assign w_rshift   = bus.bus_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ld_ext = w_rshift;
    case (r_ext)
      4'd1:    w_ld_ext = {{(XLEN-32){w_rshift[31]}}, w_rshift[31:0]};
      4'd2:    w_ld_ext = {{(XLEN-32){1'b0}}, w_rshift[31:0]};
      default: w_ld_ext = w_rshift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_core_req) w_state_nxt = S_ADDR;
      S_ADDR: begin
        if (w_hs)       w_state_nxt = (!r_we && !bus.bus_rvalid) ? S_WAIT : S_DONE;
        else if (w_tmo) w_state_nxt = S_ERR;
      end
      S_WAIT: begin
        if (bus.bus_rvalid) w_state_nxt = S_DONE;
        else if (w_tmo)     w_state_nxt = S_ERR;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_stall       = w_accept || (r_state == S_ADDR) || (r_state == S_WAIT);
    o_done        = (r_state == S_DONE) || (r_state == S_ERR);
    o_err         = (r_state == S_ERR);
    bus.bus_valid = (r_state == S_ADDR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_off     <= '0;
      r_ext     <= '0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_wmask   <= '0;
      r_wdata   <= '0;
      r_ld_data <= '0;
    end else begin
      if ((r_state == S_ADDR) || (r_state == S_WAIT)) r_cnt <= w_cnt_inc;
      else                                            r_cnt <= '0;
      if (w_accept) begin
        r_we    <= i_core_we;
        r_off   <= i_core_addr[2:0];
        r_ext   <= i_core_ext;
        r_wen   <= i_core_we;
        r_addr  <= {i_core_addr[XLEN-1:3], 3'b000};
        r_wmask <= w_wmask_al;
        r_wdata <= w_wdata_al;
      end
      if (w_capture)                r_ld_data <= w_ld_ext;
      else if (w_state_nxt == S_ERR) r_ld_data <= '0;
    end
  end

  assign bus.bus_wen   = r_wen;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_wmask = r_wmask;
  assign bus.bus_wdata = r_wdata;
  assign o_ld_data     = r_ld_data;

endmodule
